fpga_ram_lvt_nr_mw: RTL and testbench

//  Parametrised multi-read, multi-write FPGA RAM for the physical register file and rename tables.

---
 rtl/fpga_ram_lvt_nr_mw_pkg.sv | 11 +
 rtl/fpga_ram_nr1w.sv | 24 ++
 rtl/fpga_ram_lvt_nr_mw.sv | 68 ++++++
 tb/tb_fpga_ram_lvt_nr_mw.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fpga_ram_lvt_nr_mw_pkg.sv
// fpga_ram_lvt_nr_mw_pkg: shared register-count constants and address/LVT width helpers for the LVT RAM
package fpga_ram_lvt_nr_mw_pkg;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  function automatic int addr_bits(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic int lvt_bits(input int wports);
    return wports > 1 ? $clog2(wports) : 1;
  endfunction
endpackage

// File: rtl/fpga_ram_nr1w.sv
// fpga_ram_nr1w: one-write, RPORTS-async-read bank without reset (clk, we, waddr, wdata, raddr, rdata)
module fpga_ram_nr1w
  import fpga_ram_lvt_nr_mw_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int RPORTS = 7,
  localparam int AW = addr_bits(DEPTH)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [RPORTS*AW-1:0]     raddr,
  output logic [RPORTS*WIDTH-1:0]  rdata
);
  localparam logic [AW:0] DEP = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (we && ({1'b0, waddr} < DEP)) r_mem[waddr] <= wdata;
  for (genvar r = 0; r < RPORTS; r++) begin : g_rd
    assign rdata[r*WIDTH +: WIDTH] = ({1'b0, raddr[r*AW +: AW]} < DEP) ? r_mem[raddr[r*AW +: AW]] : '0;
  end
endmodule

// File: rtl/fpga_ram_lvt_nr_mw.sv
// fpga_ram_lvt_nr_mw: multi-read/multi-write LVT RAM (clk, rst, raddr->rdata, we/waddr/wdata), optional bypass and output register
module fpga_ram_lvt_nr_mw
  import fpga_ram_lvt_nr_mw_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int RPORTS = 7,
  parameter int WPORTS = 2,
  parameter int READ_LATENCY = 0,
  parameter int BYPASS = 1,
  localparam int AW = addr_bits(DEPTH),
  localparam int LW = lvt_bits(WPORTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RPORTS*AW-1:0]     raddr,
  output logic [RPORTS*WIDTH-1:0]  rdata,
  input  logic [WPORTS-1:0]        we,
  input  logic [WPORTS*AW-1:0]     waddr,
  input  logic [WPORTS*WIDTH-1:0]  wdata
);
  localparam logic [AW:0] DEP = (AW+1)'(DEPTH);
  logic [LW-1:0] r_lvt [DEPTH];
  logic [DEPTH-1:0] r_written;
  logic [RPORTS*WIDTH-1:0] w_bank [WPORTS];
  logic [RPORTS*WIDTH-1:0] w_rdata;
  logic [WPORTS-1:0] w_wv;
  for (genvar w = 0; w < WPORTS; w++) begin : g_bank
    assign w_wv[w] = we[w] && !rst && ({1'b0, waddr[w*AW +: AW]} < DEP);
    fpga_ram_nr1w #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RPORTS(RPORTS)) u_bank (
      .clk(clk),
      .we(w_wv[w]),
      .waddr(waddr[w*AW +: AW]),
      .wdata(wdata[w*WIDTH +: WIDTH]),
      .raddr(raddr),
      .rdata(w_bank[w])
    );
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_written <= '0;
      for (int i = 0; i < DEPTH; i++) r_lvt[i] <= '0;
    end else
      for (int w = 0; w < WPORTS; w++)
        if (w_wv[w]) begin
          r_lvt[waddr[w*AW +: AW]] <= LW'(w);
          r_written[waddr[w*AW +: AW]] <= 1'b1;
        end
  for (genvar r = 0; r < RPORTS; r++) begin : g_rd
    logic [AW-1:0] w_a;
    logic [WIDTH-1:0] w_d;
    assign w_a = raddr[r*AW +: AW];
    always_comb begin
      w_d = (({1'b0, w_a} < DEP) && r_written[w_a]) ? w_bank[r_lvt[w_a]][r*WIDTH +: WIDTH] : '0;
      for (int w = 0; w < WPORTS; w++)
        if (BYPASS != 0 && w_wv[w] && waddr[w*AW +: AW] == w_a) w_d = wdata[w*WIDTH +: WIDTH];
      w_d = rst ? '0 : w_d;
    end
    assign w_rdata[r*WIDTH +: WIDTH] = w_d;
  end
  if (READ_LATENCY == 1) begin : g_reg
    logic [RPORTS*WIDTH-1:0] r_rdata;
    always_ff @(posedge clk) r_rdata <= rst ? '0 : w_rdata;
    assign rdata = r_rdata;
  end else begin : g_comb
    assign rdata = w_rdata;
  end
endmodule

// File: tb/tb_fpga_ram_lvt_nr_mw.sv
// tb_fpga_ram_lvt_nr_mw: directed checks of a combinational/bypass instance and a registered/read-first/20-deep instance
module tb_fpga_ram_lvt_nr_mw;
  logic clk, rst;
  logic [34:0] raddr;
  logic [223:0] rdata0, rdata1;
  logic [1:0] we;
  logic [9:0] waddr;
  logic [63:0] wdata;
  int tests = 0;
  int fails = 0;
  fpga_ram_lvt_nr_mw dut0 (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata0), .we(we), .waddr(waddr), .wdata(wdata)
  );
  fpga_ram_lvt_nr_mw #(.DEPTH(20), .READ_LATENCY(1), .BYPASS(0)) dut1 (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata1), .we(we), .waddr(waddr), .wdata(wdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] rd0(input int p);
    return rdata0[p*32 +: 32];
  endfunction
  function automatic logic [31:0] rd1(input int p);
    return rdata1[p*32 +: 32];
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic all_rd(input logic [4:0] a);
    raddr = {7{a}};
  endtask
  task automatic test_reset;
    rst = 1'b1; we = '0; waddr = '0; wdata = '0; raddr = '0;
    tick(); tick();
    we = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'hDEAD, 32'hBEEF}; all_rd(5'd3);
    #1;
    for (int p = 0; p < 7; p++) begin
      tests++;
      if (rd0(p) !== 32'h0) begin fails++; $display("FAIL reset_during_dut0 port=%0d got=%h exp=0", p, rd0(p)); end
    end
    tick();
    for (int p = 0; p < 7; p++) begin
      tests++;
      if (rd1(p) !== 32'h0) begin fails++; $display("FAIL reset_reg_dut1 port=%0d got=%h exp=0", p, rd1(p)); end
    end
    rst = 1'b0; we = '0;
    for (int a = 0; a < 32; a++) begin
      all_rd(5'(a));
      #1;
      for (int p = 0; p < 7; p++) begin
        tests++;
        if (rd0(p) !== 32'h0) begin fails++; $display("FAIL sweep_dut0 addr=%0d port=%0d got=%h exp=0", a, p, rd0(p)); end
      end
      tick();
      for (int p = 0; p < 7; p++) begin
        tests++;
        if (rd1(p) !== 32'h0) begin fails++; $display("FAIL sweep_dut1 addr=%0d port=%0d got=%h exp=0", a, p, rd1(p)); end
      end
    end
  endtask
  task automatic test_write;
    we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hA5A5_0001;
    tick();
    we = '0; raddr[15 +: 5] = 5'd5;
    #1;
    tests++;
    if (rd0(3) !== 32'hA5A5_0001) begin fails++; $display("FAIL write_dut0 got=%h exp=a5a50001", rd0(3)); end
    tick();
    tests++;
    if (rd1(3) !== 32'hA5A5_0001) begin fails++; $display("FAIL write_dut1 got=%h exp=a5a50001", rd1(3)); end
  endtask
  task automatic test_same_addr;
    we = 2'b11; waddr = {5'd9, 5'd9}; wdata = {32'h22, 32'h11};
    tick();
    we = '0; all_rd(5'd9);
    #1;
    for (int p = 0; p < 7; p++) begin
      tests++;
      if (rd0(p) !== 32'h22) begin fails++; $display("FAIL same_addr_dut0 port=%0d got=%h exp=22", p, rd0(p)); end
    end
    tick();
    for (int p = 0; p < 7; p++) begin
      tests++;
      if (rd1(p) !== 32'h22) begin fails++; $display("FAIL same_addr_dut1 port=%0d got=%h exp=22", p, rd1(p)); end
    end
  endtask
  task automatic test_lvt_switch;
    we = 2'b01; waddr[4:0] = 5'd9; wdata[31:0] = 32'h33;
    tick();
    we = '0; all_rd(5'd9);
    #1;
    for (int p = 0; p < 7; p++) begin
      tests++;
      if (rd0(p) !== 32'h33) begin fails++; $display("FAIL lvt_switch_dut0 port=%0d got=%h exp=33", p, rd0(p)); end
    end
    tick();
    for (int p = 0; p < 7; p++) begin
      tests++;
      if (rd1(p) !== 32'h33) begin fails++; $display("FAIL lvt_switch_dut1 port=%0d got=%h exp=33", p, rd1(p)); end
    end
  endtask
  task automatic test_bypass;
    we = 2'b01; waddr[4:0] = 5'd4; wdata[31:0] = 32'h1234;
    tick();
    wdata[31:0] = 32'hBEEF; raddr = '0; raddr[4:0] = 5'd4;
    #1;
    tests++;
    if (rd0(0) !== 32'hBEEF) begin fails++; $display("FAIL bypass_dut0 got=%h exp=beef", rd0(0)); end
    tick();
    tests++;
    if (rd1(0) !== 32'h1234) begin fails++; $display("FAIL readfirst_dut1 got=%h exp=1234", rd1(0)); end
    we = 2'b11; waddr = {5'd4, 5'd4}; wdata = {32'hBBBB, 32'hAAAA};
    #1;
    tests++;
    if (rd0(0) !== 32'hBBBB) begin fails++; $display("FAIL bypass_prio_dut0 got=%h exp=bbbb", rd0(0)); end
    tick();
    tests++;
    if (rd1(0) !== 32'hBEEF) begin fails++; $display("FAIL readfirst2_dut1 got=%h exp=beef", rd1(0)); end
    we = '0;
    #1;
    tests++;
    if (rd0(0) !== 32'hBBBB) begin fails++; $display("FAIL after_prio_dut0 got=%h exp=bbbb", rd0(0)); end
    tick();
    tests++;
    if (rd1(0) !== 32'hBBBB) begin fails++; $display("FAIL after_prio_dut1 got=%h exp=bbbb", rd1(0)); end
    we = 2'b10; waddr[9:5] = 5'd6; wdata[63:32] = 32'h66; raddr[9:5] = 5'd6;
    #1;
    tests++;
    if (rd0(1) !== 32'h66) begin fails++; $display("FAIL bypass_port1_dut0 got=%h exp=66", rd0(1)); end
    tick();
    tests++;
    if (rd1(1) !== 32'h0) begin fails++; $display("FAIL readfirst_port1_dut1 got=%h exp=0", rd1(1)); end
    we = '0;
  endtask
  task automatic test_out_of_range;
    we = 2'b01; waddr[4:0] = 5'd25; wdata[31:0] = 32'h2525;
    tick();
    waddr[4:0] = 5'd19; wdata[31:0] = 32'h1919; all_rd(5'd25);
    #1;
    tests++;
    if (rd0(0) !== 32'h2525) begin fails++; $display("FAIL high_addr_dut0 got=%h exp=2525", rd0(0)); end
    tick();
    tests++;
    if (rd1(0) !== 32'h0) begin fails++; $display("FAIL oor_dut1 got=%h exp=0", rd1(0)); end
    we = '0; all_rd(5'd19);
    #1;
    tests++;
    if (rd0(0) !== 32'h1919) begin fails++; $display("FAIL last_dut0 got=%h exp=1919", rd0(0)); end
    tick();
    tests++;
    if (rd1(0) !== 32'h1919) begin fails++; $display("FAIL last_dut1 got=%h exp=1919", rd1(0)); end
  endtask
  task automatic test_reset_clear;
    we = 2'b01; waddr[4:0] = 5'd7; wdata[31:0] = 32'h77;
    tick();
    rst = 1'b1; waddr[4:0] = 5'd8; wdata[31:0] = 32'h88;
    tick();
    rst = 1'b0; we = '0; raddr = '0; raddr[4:0] = 5'd7; raddr[9:5] = 5'd8;
    #1;
    tests++;
    if (rd0(0) !== 32'h0) begin fails++; $display("FAIL clr7_dut0 got=%h exp=0", rd0(0)); end
    tests++;
    if (rd0(1) !== 32'h0) begin fails++; $display("FAIL clr8_dut0 got=%h exp=0", rd0(1)); end
    tick();
    tests++;
    if (rd1(0) !== 32'h0) begin fails++; $display("FAIL clr7_dut1 got=%h exp=0", rd1(0)); end
    tests++;
    if (rd1(1) !== 32'h0) begin fails++; $display("FAIL clr8_dut1 got=%h exp=0", rd1(1)); end
    we = 2'b01; waddr[4:0] = 5'd7; wdata[31:0] = 32'h707;
    tick();
    we = '0;
    #1;
    tests++;
    if (rd0(0) !== 32'h707) begin fails++; $display("FAIL rewrite_dut0 got=%h exp=707", rd0(0)); end
    tick();
    tests++;
    if (rd1(0) !== 32'h707) begin fails++; $display("FAIL rewrite_dut1 got=%h exp=707", rd1(0)); end
  endtask
  initial begin
    test_reset();
    test_write();
    test_same_addr();
    test_lvt_switch();
    test_bypass();
    test_out_of_range();
    test_reset_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
